// File: rtl/mul_add.sv
// Signed gated-add / Baugh-Wooley multiply unit with full-width and wrapped results.
// Define MUL_ADD_REG_EN to register Out/Prod/Ovf (1-cycle latency); otherwise purely combinational.
module mul_add #(
  parameter int WIDTH = 8
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  input  logic                      EnA,
  input  logic                      EnB,
  input  logic                      Mul,
  output logic signed [WIDTH-1:0]   Out,
  output logic signed [2*WIDTH-1:0] Prod,
  output logic                      Ovf
);

  localparam int PW = 2 * WIDTH;
  // Baugh-Wooley constant: +2^WIDTH and +2^(2*WIDTH-1) compensate the inverted sign-row terms.
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_o);
    return (sign_a == sign_b) && (sign_o != sign_a);
  endfunction

  function automatic logic mul_ovf(input logic [PW-1:0] p);
    return !((&p[PW-1:WIDTH-1]) || !(|p[PW-1:WIDTH-1]));
  endfunction

  logic [PW-1:0]              pp [WIDTH];
  logic [PW-1:0]              mul_acc;
  logic signed [WIDTH-1:0]    term_a;
  logic signed [WIDTH-1:0]    term_b;
  logic signed [WIDTH:0]      add_sum;
  logic signed [PW-1:0]       add_prod;
  logic signed [PW-1:0]       prod_p0;
  logic signed [WIDTH-1:0]    out_p0;
  logic                       ovf_p0;

  // Partial-product rows; bits pairing exactly one sign bit are inverted.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (A[j] & B[i]) ^ ((i == WIDTH - 1) != (j == WIDTH - 1));
      end
    end
  end

  always_comb begin
    mul_acc = BW_CORR;
    for (int i = 0; i < WIDTH; i++) begin
      mul_acc = mul_acc + pp[i];
    end
  end

  assign term_a   = EnA ? A : '0;
  assign term_b   = EnB ? B : '0;
  assign add_sum  = {term_a[WIDTH-1], term_a} + {term_b[WIDTH-1], term_b};
  assign add_prod = {{(WIDTH-1){add_sum[WIDTH]}}, add_sum};

  // Stage p0: combinational result select
  always_comb begin
    prod_p0 = Mul ? signed'(mul_acc) : add_prod;
    out_p0  = prod_p0[WIDTH-1:0];
    ovf_p0  = Mul ? mul_ovf(mul_acc)
                  : add_ovf(term_a[WIDTH-1], term_b[WIDTH-1], add_sum[WIDTH-1]);
  end

`ifdef MUL_ADD_REG_EN
  logic signed [PW-1:0]    prod_p1;
  logic signed [WIDTH-1:0] out_p1;
  logic                    ovf_p1;

  // Stage p1: output register, reset wins over capture
  always_ff @(posedge Clock) begin
    if (nReset) begin
      prod_p1 <= '0;
      out_p1  <= '0;
      ovf_p1  <= 1'b0;
    end else begin
      prod_p1 <= prod_p0;
      out_p1  <= out_p0;
      ovf_p1  <= ovf_p0;
    end
  end

  assign Prod = prod_p1;
  assign Out  = out_p1;
  assign Ovf  = ovf_p1;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = Clock ^ nReset;

  assign Prod = prod_p0;
  assign Out  = out_p0;
  assign Ovf  = ovf_p0;
`endif

endmodule

// File: tb/tb_mul_add.sv
// Directed bench for mul_add; covers the combinational build and, with MUL_ADD_REG_EN, the registered build.
module tb_mul_add;

  logic               Clock;
  logic               nReset;
  logic signed [7:0]  A;
  logic signed [7:0]  B;
  logic               EnA;
  logic               EnB;
  logic               Mul;
  logic signed [7:0]  Out;
  logic signed [15:0] Prod;
  logic               Ovf;

  int n_checks;
  int n_fail;

  mul_add #(.WIDTH(8)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .A      (A),
    .B      (B),
    .EnA    (EnA),
    .EnB    (EnB),
    .Mul    (Mul),
    .Out    (Out),
    .Prod   (Prod),
    .Ovf    (Ovf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive inputs away from the rising edge, then wait until the result is visible.
  task automatic apply(input logic [7:0] a, input logic [7:0] b,
                       input logic ea, input logic eb, input logic m);
    @(negedge Clock);
    A = a; B = b; EnA = ea; EnB = eb; Mul = m;
`ifdef MUL_ADD_REG_EN
    @(posedge Clock);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset;
`ifdef MUL_ADD_REG_EN
    @(negedge Clock);
    nReset = 1'b1; A = 8'd9; B = 8'd9; EnA = 1'b1; EnB = 1'b1; Mul = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h00, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_init: got %h want %h", {Out, Prod, Ovf}, {8'h00, 16'h0000, 1'b0});
    end
    @(negedge Clock);
    nReset = 1'b0;
`else
    // Reset is ignored in the combinational build.
    nReset = 1'b1;
    apply(8'd20, 8'd22, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'd42, 16'd42, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ignored: got %h want %h", {Out, Prod, Ovf}, {8'd42, 16'd42, 1'b0});
    end
    nReset = 1'b0;
`endif
  endtask

  task automatic test_add;
    apply(8'd20, 8'd22, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'd42, 16'd42, 1'b0}) begin
      n_fail++;
      $display("FAIL add_20_22: got %h want %h", {Out, Prod, Ovf}, {8'd42, 16'd42, 1'b0});
    end
    apply(8'hFB, 8'hFD, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'hF8, 16'hFFF8, 1'b0}) begin
      n_fail++;
      $display("FAIL add_neg: got %h want %h", {Out, Prod, Ovf}, {8'hF8, 16'hFFF8, 1'b0});
    end
  endtask

  task automatic test_gating;
    apply(8'd100, 8'hFB, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'hFB, 16'hFFFB, 1'b0}) begin
      n_fail++;
      $display("FAIL gate_b_only: got %h want %h", {Out, Prod, Ovf}, {8'hFB, 16'hFFFB, 1'b0});
    end
    apply(8'd100, 8'hFB, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h64, 16'h0064, 1'b0}) begin
      n_fail++;
      $display("FAIL gate_a_only: got %h want %h", {Out, Prod, Ovf}, {8'h64, 16'h0064, 1'b0});
    end
    apply(8'd100, 8'hFB, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h00, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL gate_none: got %h want %h", {Out, Prod, Ovf}, {8'h00, 16'h0000, 1'b0});
    end
  endtask

  task automatic test_add_ovf;
    apply(8'd127, 8'd1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h80, 16'h0080, 1'b1}) begin
      n_fail++;
      $display("FAIL add_ovf_pos: got %h want %h", {Out, Prod, Ovf}, {8'h80, 16'h0080, 1'b1});
    end
    apply(8'h80, 8'hFF, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h7F, 16'hFF7F, 1'b1}) begin
      n_fail++;
      $display("FAIL add_ovf_neg: got %h want %h", {Out, Prod, Ovf}, {8'h7F, 16'hFF7F, 1'b1});
    end
  endtask

  task automatic test_mul;
    apply(8'hFD, 8'd7, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'hEB, 16'hFFEB, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_m3x7: got %h want %h", {Out, Prod, Ovf}, {8'hEB, 16'hFFEB, 1'b0});
    end
    apply(8'hFD, 8'd7, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'hEB, 16'hFFEB, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_en_ignored: got %h want %h", {Out, Prod, Ovf}, {8'hEB, 16'hFFEB, 1'b0});
    end
    apply(8'h80, 8'h80, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h00, 16'h4000, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_min_min: got %h want %h", {Out, Prod, Ovf}, {8'h00, 16'h4000, 1'b1});
    end
    apply(8'd127, 8'd127, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h01, 16'h3F01, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_max_max: got %h want %h", {Out, Prod, Ovf}, {8'h01, 16'h3F01, 1'b1});
    end
    apply(8'd127, 8'h80, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h80, 16'hC080, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_max_min: got %h want %h", {Out, Prod, Ovf}, {8'h80, 16'hC080, 1'b1});
    end
    apply(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h01, 16'h0001, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_m1xm1: got %h want %h", {Out, Prod, Ovf}, {8'h01, 16'h0001, 1'b0});
    end
    apply(8'd12, 8'hF6, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h88, 16'hFF88, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_fit_neg: got %h want %h", {Out, Prod, Ovf}, {8'h88, 16'hFF88, 1'b0});
    end
    apply(8'd16, 8'd8, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h80, 16'h0080, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_ovf_128: got %h want %h", {Out, Prod, Ovf}, {8'h80, 16'h0080, 1'b1});
    end
  endtask

  task automatic test_pass_through;
    apply(8'd1, 8'hA5, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'hA5, 16'hFFA5, 1'b0}) begin
      n_fail++;
      $display("FAIL pass_a5: got %h want %h", {Out, Prod, Ovf}, {8'hA5, 16'hFFA5, 1'b0});
    end
    apply(8'd1, 8'h7F, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h7F, 16'h007F, 1'b0}) begin
      n_fail++;
      $display("FAIL pass_7f: got %h want %h", {Out, Prod, Ovf}, {8'h7F, 16'h007F, 1'b0});
    end
  endtask

  task automatic test_latency;
`ifdef MUL_ADD_REG_EN
    // Flush to a known zero, then check the result is not visible before the capturing edge.
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    nReset = 1'b0; A = 8'd5; B = 8'd6; EnA = 1'b0; EnB = 1'b0; Mul = 1'b1;
    #1;
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h00, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL lat_before_edge: got %h want %h", {Out, Prod, Ovf}, {8'h00, 16'h0000, 1'b0});
    end
    @(posedge Clock); #1;
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'd30, 16'd30, 1'b0}) begin
      n_fail++;
      $display("FAIL lat_after_edge: got %h want %h", {Out, Prod, Ovf}, {8'd30, 16'd30, 1'b0});
    end
    // Reset together with a new input: reset wins.
    @(negedge Clock);
    nReset = 1'b1; A = 8'd9; B = 8'd9;
    @(posedge Clock); #1;
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h00, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_priority: got %h want %h", {Out, Prod, Ovf}, {8'h00, 16'h0000, 1'b0});
    end
    // First post-reset input appears one edge later.
    @(negedge Clock);
    nReset = 1'b0; A = 8'd2; B = 8'd3;
    #1;
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'h00, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_hold: got %h want %h", {Out, Prod, Ovf}, {8'h00, 16'h0000, 1'b0});
    end
    @(posedge Clock); #1;
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'd6, 16'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_first: got %h want %h", {Out, Prod, Ovf}, {8'd6, 16'd6, 1'b0});
    end
`else
    // Zero latency: a new input shows up without any clock edge.
    @(posedge Clock); #1;
    A = 8'd5; B = 8'd6; EnA = 1'b0; EnB = 1'b0; Mul = 1'b1;
    #1;
    n_checks++;
    if ({Out, Prod, Ovf} !== {8'd30, 16'd30, 1'b0}) begin
      n_fail++;
      $display("FAIL comb_zero_latency: got %h want %h", {Out, Prod, Ovf}, {8'd30, 16'd30, 1'b0});
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nReset   = 1'b1;
    A = '0; B = '0; EnA = 1'b0; EnB = 1'b0; Mul = 1'b0;
    test_reset();
    test_add();
    test_gating();
    test_add_ovf();
    test_mul();
    test_pass_through();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
